// File: rtl/ps2_host_tx_if.sv
// Command/status and PS/2 pin bundle for the PS/2 host transmitter.
// slave is the transmitter side, master the requester/pin side.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, tx_done, tx_error, err_code, busy,
        output ps2_clk_oe, ps2_dat_oe
    );

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, tx_done, tx_error, err_code, busy,
        input  ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pull-low enables.
// Optional PS2_HOST_TX_RETRY_EN: one internal retry before reporting an error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);
    localparam int IW  = $clog2(INHIBIT_CYCLES);
    localparam int SW  = $clog2(START_TIMEOUT);
    localparam int PW  = $clog2(PACKET_TIMEOUT);
    localparam int CW0 = (IW > SW) ? IW : SW;
    localparam int CW  = (CW0 > PW) ? CW0 : PW;

    localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] ST_TC    = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] PK_TC    = CW'(PACKET_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    bit_q;
    logic [7:0]    data_q;
    logic          par_q;
    logic          clk_oe_q;
    logic          dat_oe_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic [1:0]    code_q;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [1:0]    fail_code;
    logic [9:0]    frame;
    logic          clk_s;
    logic          dat_s;
    logic          clk_fall;
`ifdef PS2_HOST_TX_RETRY_EN
    logic          retry_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], bus.ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat_in};
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign frame    = {1'b1, par_q, data_q};
    assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Timeouts are checked ahead of edge handling so they win a tie.
    always_comb begin
        fail_code = 2'b00;
        if (state_q == REQ && cnt_q == ST_TC)
            fail_code = 2'b01;
        else if ((state_q == SHIFT || state_q == ACK ||
                  state_q == WAIT_IDLE) && cnt_q == PK_TC)
            fail_code = 2'b10;
        else if (state_q == ACK && clk_fall && dat_s)
            fail_code = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 2'b00;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (fail_code != 2'b00) begin
`ifdef PS2_HOST_TX_RETRY_EN
                if (!retry_q) begin
                    retry_q  <= 1'b1;
                    state_q  <= INHIBIT;
                    cnt_q    <= '0;
                    clk_oe_q <= 1'b1;
                    dat_oe_q <= 1'b0;
                end else
`endif
                begin
                    state_q  <= ERR;
                    error_q  <= 1'b1;
                    code_q   <= fail_code;
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.tx_valid) begin
                            data_q   <= bus.tx_data;
                            par_q    <= ~^bus.tx_data;
                            code_q   <= 2'b00;
                            ready_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            clk_oe_q <= 1'b1;
                            state_q  <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                            retry_q  <= 1'b0;
`endif
                        end
                    end
                    INHIBIT: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == INH_PRE)
                            dat_oe_q <= 1'b1;
                        if (cnt_q == INH_LAST) begin
                            clk_oe_q <= 1'b0;
                            dat_oe_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= REQ;
                        end
                    end
                    REQ: begin
                        cnt_q <= cnt_d;
                        if (clk_fall) begin
                            dat_oe_q <= ~data_q[0];
                            bit_q    <= 4'd1;
                            cnt_q    <= '0;
                            state_q  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        cnt_q <= cnt_d;
                        if (clk_fall) begin
                            dat_oe_q <= ~frame[bit_q];
                            bit_q    <= bit_q + 4'd1;
                            if (bit_q == 4'd9)
                                state_q <= ACK;
                        end
                    end
                    ACK: begin
                        cnt_q <= cnt_d;
                        if (clk_fall)
                            state_q <= WAIT_IDLE;
                    end
                    WAIT_IDLE: begin
                        cnt_q <= cnt_d;
                        if (clk_s && dat_s) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    DONE, ERR: begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx_ready   = ready_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_error   = error_q;
    assign bus.err_code   = code_q;
    assign bus.busy       = busy_q;
    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scaled-down open-drain device model.
// Table of command/device-behaviour records plus reset-mid-frame sequence.
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int ST  = 300;
    localparam int PK  = 2000;
    localparam int H   = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    ps2_host_tx_if bus ();

    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .PACKET_TIMEOUT (PK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     done_n = 0;
    int     err_n = 0;
    int     ready_bad = 0;
    longint cyc = 0;
    longint err_cyc = 0;
    longint t0 = 0;
    logic   prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and the ready-after-pulse rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_pulse && !bus.tx_ready) ready_bad++;
        if (bus.tx_done) done_n++;
        if (bus.tx_error) begin
            err_n++;
            err_cyc = cyc;
        end
        prev_pulse = bus.tx_done | bus.tx_error;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        int          mode;
        logic [10:0] bits;
        logic        exp_done;
        logic [1:0]  code;
    } vec_t;

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!bus.tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("accept_busy", bus.busy, 1);
        chk("accept_code_clear", bus.err_code, 0);
    endtask

    task automatic inhibit();
        int m = 0;
        int first = -1;
        while (bus.ps2_clk_oe && m < INH + 50) begin
            m++;
            if (bus.ps2_dat_oe && first < 0) first = m;
            @(negedge clk);
        end
        chk("inhibit_len", m, INH);
        chk("dat_oe_last_inhibit", first, INH);
        chk("start_bit_driven", bus.ps2_dat_oe, 1);
    endtask

    task automatic clocks(input int n, input bit ack, output logic [10:0] cap);
        cap = '0;
        for (int k = 0; k < n; k++) begin
            repeat (H) @(negedge clk);
            cap[k] = bus.ps2_dat_in;
            if (k == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (k == 0) t0 = cyc;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (ack) begin
            repeat (H) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 4 * PK) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic run_vec(input vec_t x, input int i);
        logic [10:0] cap;
        int d0 = done_n;
        int e0 = err_n;
        int n;
        string tag = $sformatf("v%0d", i);
        send(x.data);
        inhibit();
        case (x.mode)
            0, 1: begin
                clocks(11, x.mode == 0, cap);
                chk({tag, "_bits"}, cap, x.bits);
            end
            2: begin
                clocks(6, 1'b0, cap);
                wait_idle(tag);
                n = int'(err_cyc - t0);
                chk({tag, "_pkt_timeout_window"}, (n >= PK && n <= PK + 3), 1);
            end
            default: begin
                n = 0;
                while (!bus.tx_error && n < ST + 50) begin
                    n++;
                    @(negedge clk);
                end
                chk({tag, "_start_timeout"}, n, ST);
                chk({tag, "_clk_released"}, bus.ps2_clk_oe, 0);
                chk({tag, "_dat_released"}, bus.ps2_dat_oe, 0);
            end
        endcase
        wait_idle(tag);
        repeat (2) @(negedge clk);
        chk({tag, "_done_pulses"}, done_n - d0, x.exp_done ? 1 : 0);
        chk({tag, "_error_pulses"}, err_n - e0, x.exp_done ? 0 : 1);
        chk({tag, "_err_code"}, bus.err_code, x.code);
        chk({tag, "_lines_free"}, {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    endtask

    vec_t v[7];

    initial begin
        logic [10:0] cap;
        int d0;
        int e0;
        // bits = {stop, parity, data[7:0], start}
        v[0] = '{8'hED, 0, 11'b11111011010, 1'b1, 2'b00};
        v[1] = '{8'hF4, 0, 11'b10111101000, 1'b1, 2'b00};
        v[2] = '{8'h00, 0, 11'b11000000000, 1'b1, 2'b00};
        v[3] = '{8'hA5, 1, 11'b11101001010, 1'b0, 2'b11};
        v[4] = '{8'hF4, 2, 11'b00000000000, 1'b0, 2'b10};
        v[5] = '{8'hED, 3, 11'b00000000000, 1'b0, 2'b01};
        v[6] = '{8'hF4, 0, 11'b10111101000, 1'b1, 2'b00};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pulses", {bus.tx_done, bus.tx_error}, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_lines", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(v[i], i);

        send(8'h55);
        inhibit();
        clocks(4, 1'b0, cap);
        chk("mid_shift_busy", bus.busy, 1);
        chk("mid_shift_dat_oe", bus.ps2_dat_oe, 1);
        d0 = done_n;
        e0 = err_n;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_mid_dat_oe", bus.ps2_dat_oe, 0);
        chk("rst_mid_ready", bus.tx_ready, 1);
        chk("rst_mid_busy", bus.busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_pulse", (done_n - d0) + (err_n - e0), 0);

        run_vec('{8'hFF, 0, 11'b11111111110, 1'b1, 2'b00}, 7);

        chk("ready_after_pulse", ready_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
